button_conditioner: RTL
=======================

# button_conditioner

Multi-channel, parametrised button front end for the blackjack game logic. It takes raw asynchronous push-button inputs, synchronises them, and debounces each channel with a per-channel stability counter clocked by a shared sample tick. For each channel it produces a clean level plus single-cycle press, release and optional auto-repeat pulses. The FSM consumes these pulses directly for hit, stand, deal and bet actions.

## Interface
Parameters:
- NUM_BTN, 4: number of independent button channels (≥1)
- TICK_DIV, 50000: CLOCK_50 cycles per sample tick (≥1); the default is 1 ms
- STABLE_TICKS, 10: consecutive differing samples required to accept a level change (≥1)
- ACTIVE_LOW, 1: 1 means a raw input of 0 is "pressed"; applies to all channels
- REPEAT_EN, 0: 1 enables auto-repeat pulses
- REPEAT_DELAY, 500: ticks of continuous hold before the first repeat pulse (≥1)
- REPEAT_RATE, 100: ticks between subsequent repeat pulses (≥1)

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- btn_raw  in  NUM_BTN  asynchronous raw button pins
- btn_level  out  NUM_BTN  debounced level, 1 = pressed
- btn_press  out  NUM_BTN  1-cycle pulse on accepted press
- btn_release  out  NUM_BTN  1-cycle pulse on accepted release
- btn_repeat  out  NUM_BTN  1-cycle auto-repeat pulse while held; constant 0 if REPEAT_EN=0

## Operation
- Sync: 2-FF chain per channel. The input is normalised so that s = btn_raw XOR ACTIVE_LOW (1 = pressed). The sync FFs reset to 0 (released).
- Tick: a free-running counter runs from 0 to TICK_DIV-1. tick is high for exactly 1 cycle when the count equals TICK_DIV-1, and the counter then wraps to 0. With TICK_DIV=1, tick is permanently high.
- Debounce, per channel, evaluated only on tick cycles:
  - s == level: cnt ← 0.
  - s != level and cnt < STABLE_TICKS-1: cnt ← cnt+1.
  - s != level and cnt == STABLE_TICKS-1: level ← s, cnt ← 0.
- Any single agreeing sample restarts the count. A glitch shorter than one tick period may go unsampled.
- Pulses:
  - btn_press is high in the first cycle btn_level reads 1.
  - btn_release is high in the first cycle btn_level reads 0 after a 1.
  - Both pulses are registered alongside level and never overlap on the same channel.
- Repeat (REPEAT_EN=1), per channel hold counter hc:
  - hc is cleared whenever level is 0 and on the press cycle.
  - While level is 1, each tick increments hc.
  - The first btn_repeat fires on the tick where hc reaches REPEAT_DELAY.
  - Further pulses fire every REPEAT_RATE ticks after that.
  - A release stops repeats immediately, and no repeat is pending afterwards.
- Channels are fully independent. Simultaneous presses on several channels give same-cycle pulses on each.

## Timing
- Reset values: btn_level=0, btn_press=0, btn_release=0, btn_repeat=0, all counters 0, sync FFs 0.
- Raw-edge-to-level latency: 2 cycles of sync, then the STABLE_TICKS-th consecutive differing tick, then +1 cycle for the output register.
  - Minimum: 2 + (STABLE_TICKS-1)·TICK_DIV + 1 cycles.
  - Maximum: about the minimum plus TICK_DIV.
- Pulses are exactly 1 CLOCK_50 cycle wide. They are never stretched to tick length.
- Reset asserted mid-operation:
  - Outputs are 0 on the next edge, and no release pulse is emitted for a channel that was pressed.
  - A button held through reset is re-detected as a fresh press STABLE_TICKS ticks after reset deasserts, and then produces btn_press.
- Counter widths:
  - tick counter: $clog2(TICK_DIV) bits, minimum 1.
  - cnt: $clog2(STABLE_TICKS) bits, minimum 1.
  - hc: $clog2(REPEAT_DELAY+REPEAT_RATE)+1 bits.
  - Counters never wrap past their terminal values.

## Structure
- Shared package bj_pkg holds:
  - CLK_HZ = 50_000_000
  - TICK_1MS = CLK_HZ/1000, the default for TICK_DIV
  - the default debounce and repeat constants
- Sub-module tick_divider (parameter DIV; ports CLOCK_50, reset, tick) holds the single shared tick counter.
- The per-channel sync, debounce and repeat logic sits in a generate loop inside button_conditioner.

## Test plan
Bench parameters: TICK_DIV=4, STABLE_TICKS=3, NUM_BTN=2, ACTIVE_LOW=1.
- Clean press: ch0 raw 1→0 and held. Required: btn_level[0] rises within 2+8+1 to 2+12+1 cycles, and btn_press[0] is high for exactly 1 cycle in the same cycle level rises.
- Bounce: ch0 raw toggles every 3 cycles for 40 cycles, then settles at 0. Required: btn_level[0] rises exactly once, only after settling, with a single btn_press[0].
- Release: after the press, ch0 raw 0→1. Required: btn_level[0] falls after 3 stable ticks, with a single btn_release[0] pulse and no btn_press[0].
- Simultaneous: both raw inputs go to 0 on the same cycle. Required: btn_press = 2'b11 in one cycle; ch1 released 5 ticks later does not disturb ch0.
- Repeat: REPEAT_EN=1, REPEAT_DELAY=5, REPEAT_RATE=2, ch0 held for 15 ticks after press. Required: btn_repeat[0] pulses at hold ticks 5, 7, 9, 11, 13, 15, and none after release.
- Reset mid-hold: ch0 pressed and level=1, reset asserted for 2 cycles. Required: all outputs 0 with no release pulse; a new btn_press[0] appears 3 ticks after reset deasserts, while raw is still 0.

Source files
------------

// File: rtl/bj_pkg.sv
// Shared constants for the blackjack front end: clock rate, sample tick and
// default debounce/auto-repeat settings.
package bj_pkg;

    localparam int CLK_HZ           = 50_000_000;
    localparam int TICK_1MS         = CLK_HZ / 1000;
    localparam int DEF_STABLE_TICKS = 10;
    localparam int DEF_REPEAT_DELAY = 500;
    localparam int DEF_REPEAT_RATE  = 100;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running divider producing a one-cycle tick every DIV clocks
// (permanently high when DIV is 1).
module tick_divider
    import bj_pkg::*;
#(
    parameter int DIV = TICK_1MS
) (
    input  logic CLOCK_50,
    input  logic reset,
    output logic tick
);

    localparam int CW = width_of(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_reg;

    assign tick = (count_reg == LAST);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            count_reg <= '0;
        end else if (tick) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: synchroniser, tick-sampled debounce and
// single-cycle press/release/auto-repeat pulses per channel.
module button_conditioner
    import bj_pkg::*;
#(
    parameter int NUM_BTN      = 4,
    parameter int TICK_DIV     = TICK_1MS,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter bit REPEAT_EN    = 1'b0,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeat
);

    localparam int CW = width_of(STABLE_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic               tick;
    logic [NUM_BTN-1:0] sync1_reg;
    logic [NUM_BTN-1:0] sync2_reg;

    tick_divider #(.DIV(TICK_DIV)) u_tick (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .tick     (tick)
    );

    // Polarity is folded in before the first flop so everything after it reads 1 = pressed.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= btn_raw ^ {NUM_BTN{ACTIVE_LOW}};
            sync2_reg <= sync1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_ch
            logic [CW-1:0] cnt_reg;
            logic          level_reg;
            logic          press_reg;
            logic          release_reg;
            logic          accept;

            // Level flips on the tick that sees the last required differing sample.
            assign accept = tick && (sync2_reg[gi] != level_reg) && (cnt_reg == CNT_LAST);

            always_ff @(posedge CLOCK_50) begin
                if (reset) begin
                    cnt_reg     <= '0;
                    level_reg   <= 1'b0;
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                end else begin
                    press_reg   <= accept && sync2_reg[gi];
                    release_reg <= accept && !sync2_reg[gi];
                    if (tick) begin
                        if (sync2_reg[gi] == level_reg) begin
                            cnt_reg <= '0;
                        end else if (accept) begin
                            level_reg <= sync2_reg[gi];
                            cnt_reg   <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
            end

            assign btn_level[gi]   = level_reg;
            assign btn_press[gi]   = press_reg;
            assign btn_release[gi] = release_reg;

            if (REPEAT_EN) begin : g_rep
                localparam int HW = $clog2(REPEAT_DELAY + REPEAT_RATE) + 1;
                localparam logic [HW-1:0] HC_FIRST = HW'(REPEAT_DELAY);
                localparam logic [HW-1:0] HC_WRAP  = HW'(REPEAT_DELAY + REPEAT_RATE);

                logic [HW-1:0] hc_reg;
                logic [HW-1:0] hc_inc;
                logic          repeat_reg;

                assign hc_inc = hc_reg + 1'b1;

                // After the first repeat the counter folds back to DELAY, so it
                // never grows past DELAY+RATE. A tick that accepts a release
                // fires nothing.
                always_ff @(posedge CLOCK_50) begin
                    if (reset) begin
                        hc_reg     <= '0;
                        repeat_reg <= 1'b0;
                    end else begin
                        repeat_reg <= 1'b0;
                        if (!level_reg || press_reg) begin
                            hc_reg <= '0;
                        end else if (tick && !accept) begin
                            if (hc_inc == HC_WRAP) begin
                                hc_reg     <= HC_FIRST;
                                repeat_reg <= 1'b1;
                            end else begin
                                hc_reg     <= hc_inc;
                                repeat_reg <= (hc_inc == HC_FIRST);
                            end
                        end
                    end
                end

                assign btn_repeat[gi] = repeat_reg;
            end else begin : g_norep
                assign btn_repeat[gi] = 1'b0;
            end
        end
    endgenerate

endmodule
